// File: rtl/cv32e40p_apu_trace_buffer.sv
// APU writeback trace buffer: timestamps register-file writebacks from
// NUM_PORTS channels into a DEPTH-entry FIFO drained over a valid/ready stream.
// Observe-only: writebacks that find no free slot are dropped and counted.
module cv32e40p_apu_trace_buffer #(
  parameter int unsigned NUM_PORTS  = 2,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned TS_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                                              clk_i,
  input  logic                                              rst_i,
  input  logic                                              enable_i,
  input  logic [NUM_PORTS-1:0]                              apu_valid_i,
  input  logic [6*NUM_PORTS-1:0]                            apu_waddr_i,
  input  logic [DATA_WIDTH*NUM_PORTS-1:0]                   apu_result_i,
  output logic                                              trc_valid_o,
  input  logic                                              trc_ready_i,
  output logic [((NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1)-1:0] trc_port_o,
  output logic                                              trc_fp_o,
  output logic [4:0]                                        trc_reg_o,
  output logic [DATA_WIDTH-1:0]                             trc_data_o,
  output logic [TS_WIDTH-1:0]                               trc_time_o,
  output logic [$clog2(DEPTH):0]                            level_o,
  output logic [CNT_WIDTH-1:0]                              drop_cnt_o,
  output logic                                              overflow_o
);

  localparam int unsigned PW   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int unsigned PTRW = $clog2(DEPTH);
  localparam int unsigned LW   = PTRW + 1;
  localparam int unsigned SW   = CNT_WIDTH + 3;

  typedef struct packed {
    logic [PW-1:0]         port;
    logic                  fp;
    logic [4:0]            rg;
    logic [DATA_WIDTH-1:0] data;
    logic [TS_WIDTH-1:0]   ts;
  } rec_t;

  rec_t                  mem [DEPTH];
  rec_t                  head;
  logic [PTRW-1:0]       rd_ptr;
  logic [PTRW-1:0]       wr_ptr;
  logic [LW-1:0]         level;
  logic                  valid_q;
  logic [TS_WIDTH-1:0]   ts;
  logic [CNT_WIDTH-1:0]  drop_cnt;
  logic                  overflow;

  logic [NUM_PORTS-1:0]  acc_c;
  logic [PTRW-1:0]       slot_c [NUM_PORTS];
  logic [LW-1:0]         free_c;
  logic [LW-1:0]         n_acc_c;
  logic [SW-1:0]         n_drop_c;
  logic [SW-1:0]         drop_sum_c;
  logic [LW-1:0]         level_nxt_c;
  logic                  pop_c;

  // Accept valid ports in ascending order into the space free at cycle start
  always_comb begin
    acc_c    = '0;
    n_acc_c  = '0;
    n_drop_c = '0;
    free_c   = LW'(DEPTH) - level;
    for (int p = 0; p < NUM_PORTS; p++) begin
      slot_c[p] = wr_ptr + PTRW'(n_acc_c);
      if (enable_i && apu_valid_i[p]) begin
        if (n_acc_c < free_c) begin
          acc_c[p] = 1'b1;
          n_acc_c  = n_acc_c + LW'(1);
        end else begin
          n_drop_c = n_drop_c + SW'(1);
        end
      end
    end
    pop_c       = valid_q && trc_ready_i;
    level_nxt_c = level + n_acc_c - LW'(pop_c);
    drop_sum_c  = SW'(drop_cnt) + n_drop_c;
  end

  // Control state: pointers, occupancy, timestamp, drop statistics
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      level    <= '0;
      valid_q  <= 1'b0;
      ts       <= '0;
      drop_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      ts      <= ts + TS_WIDTH'(1);
      wr_ptr  <= wr_ptr + PTRW'(n_acc_c);
      level   <= level_nxt_c;
      valid_q <= (level_nxt_c != '0);
      if (pop_c) begin
        rd_ptr <= rd_ptr + PTRW'(1);
      end
      if (drop_sum_c > SW'({CNT_WIDTH{1'b1}})) begin
        drop_cnt <= {CNT_WIDTH{1'b1}};
      end else begin
        drop_cnt <= CNT_WIDTH'(drop_sum_c);
      end
      if (n_drop_c != '0) begin
        overflow <= 1'b1;
      end
    end
  end

  // Record storage; contents are don't-care until pointed at by level
  always_ff @(posedge clk_i) begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (acc_c[p]) begin
        mem[slot_c[p]] <= '{port: PW'(p),
                            fp:   apu_waddr_i[6*p+5],
                            rg:   apu_waddr_i[6*p +: 5],
                            data: apu_result_i[DATA_WIDTH*p +: DATA_WIDTH],
                            ts:   ts};
      end
    end
  end

  // Head entry drives the stream fields directly
  assign head        = mem[rd_ptr];
  assign trc_valid_o = valid_q;
  assign trc_port_o  = head.port;
  assign trc_fp_o    = head.fp;
  assign trc_reg_o   = head.rg;
  assign trc_data_o  = head.data;
  assign trc_time_o  = head.ts;
  assign level_o     = level;
  assign drop_cnt_o  = drop_cnt;
  assign overflow_o  = overflow;

endmodule

// File: tb/tb_cv32e40p_apu_trace_buffer.sv
// Directed bench for the APU trace buffer (NUM_PORTS=2, DEPTH=8, CNT_WIDTH=2).
module tb_cv32e40p_apu_trace_buffer;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        enable_i;
  logic [1:0]  apu_valid_i;
  logic [11:0] apu_waddr_i;
  logic [63:0] apu_result_i;
  logic        trc_valid_o;
  logic        trc_ready_i;
  logic [0:0]  trc_port_o;
  logic        trc_fp_o;
  logic [4:0]  trc_reg_o;
  logic [31:0] trc_data_o;
  logic [31:0] trc_time_o;
  logic [3:0]  level_o;
  logic [1:0]  drop_cnt_o;
  logic        overflow_o;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int t0;
  int tf;

  always #5 clk = ~clk;

  cv32e40p_apu_trace_buffer #(
    .NUM_PORTS (2),
    .DEPTH     (8),
    .TS_WIDTH  (32),
    .DATA_WIDTH(32),
    .CNT_WIDTH (2)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .enable_i    (enable_i),
    .apu_valid_i (apu_valid_i),
    .apu_waddr_i (apu_waddr_i),
    .apu_result_i(apu_result_i),
    .trc_valid_o (trc_valid_o),
    .trc_ready_i (trc_ready_i),
    .trc_port_o  (trc_port_o),
    .trc_fp_o    (trc_fp_o),
    .trc_reg_o   (trc_reg_o),
    .trc_data_o  (trc_data_o),
    .trc_time_o  (trc_time_o),
    .level_o     (level_o),
    .drop_cnt_o  (drop_cnt_o),
    .overflow_o  (overflow_o)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance one cycle; inputs are driven and outputs sampled 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [31:0] dval(input int k, input int p);
    return 32'h1000_0000 + 32'(k * 2 + p);
  endfunction

  initial begin
    rst_i        = 1'b1;
    enable_i     = 1'b1;
    apu_valid_i  = '0;
    apu_waddr_i  = '0;
    apu_result_i = '0;
    trc_ready_i  = 1'b0;
    step();
    step();
    rst_i = 1'b0;
    cyc   = 0;
    check("rst_valid", 64'(trc_valid_o), 64'd0);
    check("rst_level", 64'(level_o), 64'd0);
    check("rst_drop", 64'(drop_cnt_o), 64'd0);
    check("rst_ovf", 64'(overflow_o), 64'd0);

    // single-port write at cycle 5
    trc_ready_i = 1'b1;
    repeat (5) step();
    apu_valid_i        = 2'b01;
    apu_waddr_i[5:0]   = 6'h23;
    apu_result_i[31:0] = 32'hDEAD_BEEF;
    step();
    apu_valid_i = 2'b00;
    check("sp_valid", 64'(trc_valid_o), 64'd1);
    check("sp_fp", 64'(trc_fp_o), 64'd1);
    check("sp_reg", 64'(trc_reg_o), 64'd3);
    check("sp_data", 64'(trc_data_o), 64'hDEAD_BEEF);
    check("sp_time", 64'(trc_time_o), 64'd5);
    check("sp_port", 64'(trc_port_o), 64'd0);
    step();
    check("sp_empty", 64'(trc_valid_o), 64'd0);

    // same-cycle ordering
    trc_ready_i  = 1'b0;
    apu_valid_i  = 2'b11;
    apu_waddr_i  = {6'h02, 6'h21};
    apu_result_i = {32'hBBBB_0001, 32'hAAAA_0000};
    t0 = cyc;
    step();
    apu_valid_i = 2'b00;
    check("ord_level", 64'(level_o), 64'd2);
    check("ord0_port", 64'(trc_port_o), 64'd0);
    check("ord0_fp", 64'(trc_fp_o), 64'd1);
    check("ord0_reg", 64'(trc_reg_o), 64'd1);
    check("ord0_data", 64'(trc_data_o), 64'hAAAA_0000);
    check("ord0_time", 64'(trc_time_o), 64'(t0));
    trc_ready_i = 1'b1;
    step();
    check("ord1_port", 64'(trc_port_o), 64'd1);
    check("ord1_fp", 64'(trc_fp_o), 64'd0);
    check("ord1_reg", 64'(trc_reg_o), 64'd2);
    check("ord1_data", 64'(trc_data_o), 64'hBBBB_0001);
    check("ord1_time", 64'(trc_time_o), 64'(t0));
    step();
    check("ord_empty", 64'(trc_valid_o), 64'd0);
    check("ord_level0", 64'(level_o), 64'd0);

    // fill to full with the consumer stalled
    trc_ready_i = 1'b0;
    apu_waddr_i = {6'h05, 6'h04};
    tf = cyc;
    for (int k = 0; k < 4; k++) begin
      apu_valid_i  = 2'b11;
      apu_result_i = {dval(k, 1), dval(k, 0)};
      step();
    end
    check("fill_level", 64'(level_o), 64'd8);
    check("fill_drop", 64'(drop_cnt_o), 64'd0);
    check("fill_ovf", 64'(overflow_o), 64'd0);
    apu_result_i = {dval(4, 1), dval(4, 0)};
    step();
    check("full_drop", 64'(drop_cnt_o), 64'd2);
    check("full_ovf", 64'(overflow_o), 64'd1);
    check("full_level", 64'(level_o), 64'd8);
    check("full_head", 64'(trc_data_o), 64'(dval(0, 0)));
    check("full_time", 64'(trc_time_o), 64'(tf));

    // pop and push against a full FIFO: the push is lost
    trc_ready_i  = 1'b1;
    apu_valid_i  = 2'b01;
    apu_result_i = {dval(5, 1), dval(5, 0)};
    step();
    check("pp_level", 64'(level_o), 64'd7);
    check("pp_drop", 64'(drop_cnt_o), 64'd3);
    check("pp_head", 64'(trc_data_o), 64'(dval(0, 1)));

    // saturation: five more drops with the counter already at its maximum
    trc_ready_i = 1'b0;
    apu_valid_i = 2'b11;
    repeat (3) step();
    check("sat_drop", 64'(drop_cnt_o), 64'd3);
    check("sat_level", 64'(level_o), 64'd8);

    // capture disabled: nothing accepted, nothing counted, drain continues
    enable_i = 1'b0;
    repeat (2) step();
    check("dis_level", 64'(level_o), 64'd8);
    check("dis_drop", 64'(drop_cnt_o), 64'd3);
    check("dis_head", 64'(trc_data_o), 64'(dval(0, 1)));
    trc_ready_i = 1'b1;
    repeat (3) step();
    check("drain_level", 64'(level_o), 64'd5);
    check("drain_head", 64'(trc_data_o), 64'(dval(2, 0)));
    check("drain_drop", 64'(drop_cnt_o), 64'd3);

    // reset in the middle of a drain
    rst_i    = 1'b1;
    enable_i = 1'b1;
    step();
    rst_i              = 1'b0;
    apu_valid_i        = 2'b01;
    apu_result_i[31:0] = 32'hCAFE_F00D;
    trc_ready_i        = 1'b0;
    check("mr_valid", 64'(trc_valid_o), 64'd0);
    check("mr_level", 64'(level_o), 64'd0);
    check("mr_ovf", 64'(overflow_o), 64'd0);
    check("mr_drop", 64'(drop_cnt_o), 64'd0);
    step();
    apu_valid_i = 2'b00;
    check("mr_level1", 64'(level_o), 64'd1);
    check("mr_data", 64'(trc_data_o), 64'hCAFE_F00D);
    check("mr_time", 64'(trc_time_o), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cv32e40p_apu_trace_buffer.md
# cv32e40p_apu_trace_buffer

Synthesizable, parametrised successor to the simulation-only APU writeback logger. It captures APU register-file writebacks from NUM_PORTS parallel writeback channels and timestamps each one with a free-running cycle counter. Records are held in a DEPTH-entry FIFO and drained through a valid/ready stream, so an on-chip trace sink or debug module can read them at its own pace. The block sits beside the core's APU writeback path and observes it only; it never applies backpressure to the core.

## Interface
Parameters:
- NUM_PORTS, 2: number of writeback channels (1..4).
- DEPTH, 8: FIFO entries; must be a power of two and at least 2.
- TS_WIDTH, 32: timestamp counter width.
- DATA_WIDTH, 32: result width.
- CNT_WIDTH, 16: drop counter width.

Ports (PW = max(1, $clog2(NUM_PORTS)), LW = $clog2(DEPTH)+1):
- clk_i, in, 1: clock. This is the block's only clock.
- rst_i, in, 1: reset, synchronous and active-high.
- enable_i, in, 1: capture enable. While low, no new records are accepted and nothing is counted as dropped.
- apu_valid_i, in, NUM_PORTS: per-port writeback valid.
- apu_waddr_i, in, 6*NUM_PORTS: per-port write address, packed with port p at bits [6p+5:6p]. Bit 5 set means an FP register.
- apu_result_i, in, DATA_WIDTH*NUM_PORTS: per-port result, packed the same way.
- trc_valid_o, out, 1: a record is available at the FIFO head.
- trc_ready_i, in, 1: the consumer accepts the head record.
- trc_port_o, out, PW: index of the source port.
- trc_fp_o, out, 1: copy of waddr bit 5.
- trc_reg_o, out, 5: copy of waddr[4:0].
- trc_data_o, out, DATA_WIDTH: captured result.
- trc_time_o, out, TS_WIDTH: timestamp captured at acceptance.
- level_o, out, LW: current FIFO occupancy.
- drop_cnt_o, out, CNT_WIDTH: saturating count of writebacks lost to a full FIFO.
- overflow_o, out, 1: sticky flag, set on the first drop.

## Operation
- Timestamp counter:
  - 0 in the cycle after reset, then +1 every cycle.
  - Wraps modulo 2^TS_WIDTH.
  - Every record accepted in a cycle gets that cycle's counter value.
- Capture, each cycle that enable_i=1:
  - Let R be the set of ports with apu_valid_i set.
  - Let F = DEPTH − occupancy at the start of the cycle. A pop in the same cycle does not add free space.
  - Ports in R are accepted in ascending port index until F slots are used. Accepted ports are written to consecutive FIFO entries, so the lower port's record is popped first.
  - Every remaining port in R is dropped. Each drop increments drop_cnt_o by 1, and the counter saturates at 2^CNT_WIDTH−1. Any drop sets overflow_o.
- Pop: a handshake occurs when trc_valid_o && trc_ready_i. The read pointer advances by 1 and occupancy decreases by 1.
- Occupancy update per cycle: next = current + accepted − popped. Push and pop in the same cycle are both honoured.
- Pointers wrap modulo DEPTH. Full means occupancy == DEPTH; empty means occupancy == 0.
- trc_valid_o = (occupancy != 0).
- trc_* fields come straight from the head entry, so they stay stable while valid is high and ready is low.
- When enable_i=0:
  - Capture is off, as described under the interface.
  - Draining continues normally.
  - The timestamp keeps counting.
- rst_i:
  - Clears pointers, occupancy, timestamp, drop_cnt_o and overflow_o.
  - Stored records are discarded, even in the middle of a drain.
  - FIFO storage contents need not be reset.
- drop_cnt_o and overflow_o are cleared only by rst_i.

## Timing
- Reset values:
  - trc_valid_o=0, level_o=0, drop_cnt_o=0, overflow_o=0.
  - trc_time internal counter = 0.
  - trc_port/fp/reg/data/time outputs are don't-care while trc_valid_o=0.
- Capture-to-visible latency is 1 cycle. A writeback in cycle N gives trc_valid_o=1 and updated level_o in cycle N+1.
- drop_cnt_o and overflow_o update 1 cycle after the dropping cycle.
- Throughput:
  - Up to NUM_PORTS pushes per cycle and 1 pop per cycle.
  - With the FIFO full, a same-cycle pop plus a writeback drops that writeback; the freed slot is usable from the next cycle.
- No combinational path from apu_*_i to any trc_* output.
- No combinational path from trc_ready_i to any output.

## Test plan
- Single-port write (defaults): reset, then at cycle 5 port0 writes waddr=0x23 with data=0xDEADBEEF, trc_ready_i=1. Required: at cycle 6, trc_valid_o=1, trc_fp_o=1, trc_reg_o=3, trc_data_o=0xDEADBEEF, trc_time_o=5, trc_port_o=0. At cycle 7, trc_valid_o=0.
- Same-cycle ordering: port1 (waddr=0x02) and port0 (waddr=0x21) both valid in one cycle. Required: level_o=2, the port0 record pops first and the port1 record second, and both carry the same trc_time_o.
- Fill to full, DEPTH=8, trc_ready_i=0:
  - 4 cycles of both ports valid give level_o=8 and drop_cnt_o=0.
  - The next cycle with both ports valid gives drop_cnt_o=2 and overflow_o=1, and the head record is unchanged.
- Full FIFO with simultaneous pop and push: at level 8, trc_ready_i=1 and one port valid. Required: that writeback is dropped, level_o=7, drop_cnt_o increments by 1.
- Saturation and enable, CNT_WIDTH=2: force 5 drops and require drop_cnt_o to stay at 3. Then with enable_i=0 and writebacks present, require no new records and no change to drop_cnt_o.
- Reset mid-drain: with level_o=5, assert rst_i for 1 cycle. Required next cycle: trc_valid_o=0, level_o=0, overflow_o=0, and the timestamp restarts at 0.
